tx_fifo: RTL



---
 rtl/tx_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tx_fifo.sv
// Transmit byte FIFO with a drain FSM feeding the UART transmitter over a start/busy handshake.
// Optional sticky overflow flag and clear input when TX_FIFO_OVF_EN is defined.
module tx_fifo #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int IRQ_LOW      = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_irq,
  output logic [1:0]            state_dbg
`ifdef TX_FIFO_OVF_EN
  ,
  output logic                  fifo_ovf,
  input  logic                  ovf_clr
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int TW    = $clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_CNT  = CW'(IRQ_LOW);
  localparam logic [CW-1:0] LOW_ABV  = CW'(IRQ_LOW + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         tcnt;
  state_t                state;
  logic                  push, pop, done;

  // Handshake: tx_start pulses one cycle with tx_data valid; the transmitter
  // answers by holding tx_busy high until the byte has shifted out.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    push       = wr_en && !fifo_full;
    pop        = (state == S_IDLE) && !fifo_empty && !tx_busy;
    done       = ((state == S_WAIT_BUSY) && !tx_busy && (tcnt == TMO_LAST)) ||
                 ((state == S_WAIT_DONE) && !tx_busy);
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tcnt     <= '0;
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      fifo_irq <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Low-water crossing or end of the final transfer with nothing left queued.
      fifo_irq <= (pop && !push && (count == LOW_ABV)) ||
                  (done && (count == '0) && !push);
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          tcnt  <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A transmitter that never answers is treated as having sent the byte.
          if (tx_busy)               state <= S_WAIT_DONE;
          else if (tcnt == TMO_LAST) state <= S_IDLE;
          else                       tcnt  <= tcnt + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)                  fifo_ovf <= 1'b0;
    else if (wr_en && fifo_full) fifo_ovf <= 1'b1;
    else if (ovf_clr)           fifo_ovf <= 1'b0;
  end
`endif

  logic unused_ok;
  assign unused_ok = ^LOW_CNT;

endmodule
